// File: rtl/ct_fcnvt_pass_seq.sv
// Multi-pass sequencer for the VFALU convert pipe (EX1-EX3).
// Splits one vector convert into N element-group passes, issues one pass
// per cycle into EX1, tracks each pass through EX2/EX3 and pulses seq_done
// when the final pass reaches EX3.
module ct_fcnvt_pass_seq #(
  parameter int MAX_PASS = 4,
  localparam int IDX_W = $clog2(MAX_PASS)
) (
  input  logic             ex1_vld_clk,
  input  logic             cpurst_b,
  input  logic             ex1_req_vld,
  input  logic [2:0]       ex1_req_pass_num,
  input  logic             rtu_yy_xx_flush,
  output logic             seq_busy,
  output logic             seq_clk_en,
  output logic             pass_pipedown,
  output logic [IDX_W-1:0] pass_idx,
  output logic             pass_last,
  output logic             ex3_pass_vld,
  output logic [IDX_W-1:0] ex3_pass_idx,
  output logic             seq_done
);

  // Pass counter and captured pass total share the request-field width.
  localparam logic [2:0] MAX_N = 3'(MAX_PASS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         total_q, total_d;
  logic [2:0]         n_norm;
  logic               issue_last;

  logic               ex2_vld_q, ex2_vld_d;
  logic [IDX_W-1:0]   ex2_idx_q, ex2_idx_d;
  logic               ex2_last_q, ex2_last_d;
  logic               ex3_vld_q, ex3_vld_d;
  logic [IDX_W-1:0]   ex3_idx_q, ex3_idx_d;
  logic               ex3_last_q, ex3_last_d;

  // Normalise the requested pass count: 0 behaves as 1, large values clamp.
  always_comb begin
    n_norm = ex1_req_pass_num;
    if (ex1_req_pass_num == 3'd0) begin
      n_norm = 3'd1;
    end else if (ex1_req_pass_num > MAX_N) begin
      n_norm = MAX_N;
    end
  end

  // FSM next state plus EX1 issue outputs; flush suppresses issue in its own cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    total_d       = total_q;
    pass_pipedown = 1'b0;
    pass_idx      = '0;
    pass_last     = 1'b0;
    issue_last    = (cnt_q == (total_q - 3'd1));
    case (state_q)
      ST_IDLE: begin
        if (ex1_req_vld && !rtu_yy_xx_flush) begin
          pass_pipedown = 1'b1;
          pass_idx      = '0;
          pass_last     = (n_norm == 3'd1);
          total_d       = n_norm;
          cnt_d         = 3'd1;
          state_d       = (n_norm == 3'd1) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!rtu_yy_xx_flush) begin
          pass_pipedown = 1'b1;
          pass_idx      = cnt_q[IDX_W-1:0];
          pass_last     = issue_last;
        end
        cnt_d = cnt_q + 3'd1;
        if (issue_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ex3_vld_q && ex3_last_q) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    if (rtu_yy_xx_flush) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end
  end

  // EX1->EX2->EX3 tracking of {vld, idx, last}; flush drops everything in flight.
  always_comb begin
    ex2_vld_d  = pass_pipedown;
    ex2_idx_d  = pass_idx;
    ex2_last_d = pass_last;
    ex3_vld_d  = ex2_vld_q;
    ex3_idx_d  = ex2_idx_q;
    ex3_last_d = ex2_last_q;
    if (rtu_yy_xx_flush) begin
      ex2_vld_d  = 1'b0;
      ex2_idx_d  = '0;
      ex2_last_d = 1'b0;
      ex3_vld_d  = 1'b0;
      ex3_idx_d  = '0;
      ex3_last_d = 1'b0;
    end
  end

  // State, counters and delay-line registers.
  always_ff @(posedge ex1_vld_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      total_q    <= 3'd0;
      ex2_vld_q  <= 1'b0;
      ex2_idx_q  <= '0;
      ex2_last_q <= 1'b0;
      ex3_vld_q  <= 1'b0;
      ex3_idx_q  <= '0;
      ex3_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      ex2_vld_q  <= ex2_vld_d;
      ex2_idx_q  <= ex2_idx_d;
      ex2_last_q <= ex2_last_d;
      ex3_vld_q  <= ex3_vld_d;
      ex3_idx_q  <= ex3_idx_d;
      ex3_last_q <= ex3_last_d;
    end
  end

  // Busy and clock request keep the gated clock alive until EX3 and DRAIN retire.
  always_comb begin
    seq_busy     = (state_q != ST_IDLE);
    seq_clk_en   = ex1_req_vld | seq_busy | ex2_vld_q | ex3_vld_q;
    ex3_pass_vld = ex3_vld_q;
    ex3_pass_idx = ex3_idx_q;
    seq_done     = ex3_vld_q & ex3_last_q;
  end

endmodule

// File: tb/tb_ct_fcnvt_pass_seq.sv
// Directed bench for ct_fcnvt_pass_seq: hand-computed per-cycle output tables.
module tb_ct_fcnvt_pass_seq;

  logic       clk;
  logic       rst_b;
  logic       req_vld;
  logic [2:0] req_num;
  logic       flush;
  logic       busy, clk_en, pipedown, last, e3_vld, done;
  logic [1:0] idx, e3_idx;

  int n_cmp = 0;
  int n_err = 0;
  int n_viol = 0;

  ct_fcnvt_pass_seq #(.MAX_PASS(4)) dut (
    .ex1_vld_clk      (clk),
    .cpurst_b         (rst_b),
    .ex1_req_vld      (req_vld),
    .ex1_req_pass_num (req_num),
    .rtu_yy_xx_flush  (flush),
    .seq_busy         (busy),
    .seq_clk_en       (clk_en),
    .pass_pipedown    (pipedown),
    .pass_idx         (idx),
    .pass_last        (last),
    .ex3_pass_vld     (e3_vld),
    .ex3_pass_idx     (e3_idx),
    .seq_done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count upstream protocol violations (request while busy) seen by the DUT.
  always @(negedge clk) begin
    if (rst_b && req_vld && busy) n_viol++;
  end

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait to the falling edge.
  task automatic cyc(input logic rb, input logic rq, input logic [2:0] num, input logic fl);
    @(posedge clk);
    #1;
    rst_b   = rb;
    req_vld = rq;
    req_num = num;
    flush   = fl;
    @(negedge clk);
  endtask

  // Compare all outputs packed as {busy,clk_en,pipedown,idx,last,e3_vld,e3_idx,done}.
  task automatic expect_out(input string tag, input logic b, input logic ce, input logic pd,
                            input logic [1:0] ix, input logic ls, input logic ev,
                            input logic [1:0] ei, input logic dn);
    check_eq(tag, {6'd0, busy, clk_en, pipedown, idx, last, e3_vld, e3_idx, done},
                  {6'd0, b, ce, pd, ix, ls, ev, ei, dn});
  endtask

  // Single-pass sequence shape (used for N=1 and clamp-from-0).
  task automatic run_single(input string tag, input logic [2:0] num);
    cyc(1, 1, num, 0); expect_out({tag, "_t0"}, 0, 1, 1, 2'd0, 1, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);   expect_out({tag, "_t1"}, 1, 1, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);   expect_out({tag, "_t2"}, 1, 1, 0, 2'd0, 0, 1, 2'd0, 1);
    cyc(1, 0, 0, 0);   expect_out({tag, "_t3"}, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
  endtask

  // Four-pass sequence shape through T+5 (used for N=4 and clamp-from-7).
  task automatic run_four(input string tag, input logic [2:0] num);
    cyc(1, 1, num, 0); expect_out({tag, "_t0"}, 0, 1, 1, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);   expect_out({tag, "_t1"}, 1, 1, 1, 2'd1, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);   expect_out({tag, "_t2"}, 1, 1, 1, 2'd2, 0, 1, 2'd0, 0);
    cyc(1, 0, 0, 0);   expect_out({tag, "_t3"}, 1, 1, 1, 2'd3, 1, 1, 2'd1, 0);
    cyc(1, 0, 0, 0);   expect_out({tag, "_t4"}, 1, 1, 0, 2'd0, 0, 1, 2'd2, 0);
    cyc(1, 0, 0, 0);   expect_out({tag, "_t5"}, 1, 1, 0, 2'd0, 0, 1, 2'd3, 1);
  endtask

  initial begin
    rst_b   = 1'b0;
    req_vld = 1'b0;
    req_num = 3'd0;
    flush   = 1'b0;
    #2;
    expect_out("reset_init", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);   expect_out("idle", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);

    // Single pass, then clamp of 0 to 1.
    run_single("n1", 3'd1);
    run_single("n0", 3'd0);

    // Four passes with back-to-back request accepted at T+6.
    run_four("n4", 3'd4);
    cyc(1, 1, 3'd1, 0); expect_out("n4_t6_newreq", 0, 1, 1, 2'd0, 1, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("n4_t7", 1, 1, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("n4_t8", 1, 1, 0, 2'd0, 0, 1, 2'd0, 1);
    cyc(1, 0, 0, 0);    expect_out("n4_t9", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);

    // Clamp of 7 to 4.
    run_four("n7", 3'd7);
    cyc(1, 0, 0, 0);    expect_out("n7_t6", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);

    // Flush mid-sequence at T+2.
    cyc(1, 1, 3'd4, 0); expect_out("fl_t0", 0, 1, 1, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("fl_t1", 1, 1, 1, 2'd1, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 1);    expect_out("fl_t2", 1, 1, 0, 2'd0, 0, 1, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("fl_t3", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("fl_t4", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);

    // Flush coincident with request in IDLE: flush wins.
    cyc(1, 1, 3'd2, 1); expect_out("flreq_t0", 0, 1, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("flreq_t1", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);

    // Illegal request during an N=3 sequence is ignored; clock enable tracking.
    cyc(1, 1, 3'd3, 0); expect_out("ill_t0", 0, 1, 1, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 1, 3'd1, 0); expect_out("ill_t1", 1, 1, 1, 2'd1, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("ill_t2", 1, 1, 1, 2'd2, 1, 1, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("ill_t3", 1, 1, 0, 2'd0, 0, 1, 2'd1, 0);
    cyc(1, 0, 0, 0);    expect_out("ill_t4", 1, 1, 0, 2'd0, 0, 1, 2'd2, 1);
    cyc(1, 0, 0, 0);    expect_out("ill_t5", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
    check_eq("viol_count", 16'(n_viol), 16'd1);

    // Reset asserted mid-ISSUE with N=4 aborts the sequence.
    cyc(1, 1, 3'd4, 0); expect_out("rst_t0", 0, 1, 1, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("rst_t1", 1, 1, 1, 2'd1, 0, 0, 2'd0, 0);
    cyc(0, 0, 0, 0);    expect_out("rst_t2_asserted", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("rst_t3", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("rst_t4", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("rst_t5", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);
    cyc(1, 0, 0, 0);    expect_out("rst_t6", 0, 0, 0, 2'd0, 0, 0, 2'd0, 0);

    // Sequencer is usable again after the abort.
    run_single("post_rst", 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ct_fcnvt_pass_seq.md
Name: ct_fcnvt_pass_seq

Overview:
- Multi-pass sequencer for the 3-stage VFALU convert pipe (EX1-EX3). One vector convert is split into N element-group passes; one pass is issued per cycle into EX1.
- Drives the EX1 pipedown, the element-group index for the datapath operand mux, and the EX3 result-buffer write enable.
- Stalls issue while a sequence is active.
- Requests its own clock through the ICG local enable. It sits beside the convert pipe-control logic in the VFALU.

Parameters:
- MAX_PASS, 4, maximum passes per op; fixes the pass index width at 2 bits.

Ports:
- ex1_vld_clk  in  1  gated clock (ICG local enable is driven from seq_clk_en)
- cpurst_b  in  1  reset, asynchronous, active-low
- ex1_req_vld  in  1  convert op presented in EX1
- ex1_req_pass_num  in  3  number of passes requested (1..MAX_PASS)
- rtu_yy_xx_flush  in  1  synchronous pipeline flush
- seq_busy  out  1  sequence active; upstream must hold off ex1_req_vld
- seq_clk_en  out  1  local clock-enable request to the ICG
- pass_pipedown  out  1  a pass enters convert EX1 this cycle
- pass_idx  out  2  element-group index of the EX1 pass
- pass_last  out  1  EX1 pass is the final pass
- ex3_pass_vld  out  1  a pass result is valid in EX3
- ex3_pass_idx  out  2  element-group index of the EX3 pass
- seq_done  out  1  one-cycle pulse when the last pass is in EX3

Behaviour:
Reset and flush
- Reset (async, cpurst_b=0): state=IDLE, pass counter=0, total=0, and all EX2/EX3 delay-stage valids, idx and last =0.
- Reset (resulting outputs): seq_busy=0 and ex3_pass_vld=0; every other output also =0 while ex1_req_vld=0.
- Reset asserted mid-sequence aborts it. No seq_done is produced.

FSM: IDLE, ISSUE, DRAIN. seq_busy = (state!=IDLE), registered.

IDLE
- Accept condition: ex1_req_vld & ~flush.
- On accept, pass 0 issues in the same cycle: pass_pipedown=1, pass_idx=0, pass_last=(N==1).
- Then N==1 -> DRAIN; N>1 -> ISSUE with counter=1.

Pass-count normalisation
- N = ex1_req_pass_num, captured at accept.
- 0 is treated as 1.
- Values above MAX_PASS clamp to MAX_PASS.

ISSUE
- Every cycle: pass_pipedown=1, pass_idx=counter, pass_last=(counter==N-1), counter++.
- After the last pass issues -> DRAIN.

DRAIN
- pass_pipedown=0.
- When the EX3 stage holds last=1 -> IDLE.

Delay line
- Two stages, EX1->EX2->EX3, each carrying {vld, idx, last}.
- ex3_pass_vld and ex3_pass_idx come from the EX3 stage.
- seq_done = EX3 vld & last (combinational from the EX3 registers).

Latency (request accepted at cycle T)
- Pass k issues at T+k.
- ex3_pass_vld for pass k at T+k+2.
- seq_done at T+N+1.
- seq_busy high T+1..T+N+1; low again at T+N+2.
- Next request is accepted no earlier than T+N+2.

Other rules
- ex1_req_vld while seq_busy=1 is a protocol violation: ignored, no state change. Bench checks it with an assertion.
- Flush, any state: next cycle state=IDLE, counter cleared, all delay valids cleared, no seq_done.
  - pass_pipedown is gated combinationally by flush in the flush cycle.
  - Flush together with ex1_req_vld in IDLE: flush wins; no pass is issued.
- seq_clk_en = ex1_req_vld | (state!=IDLE) | EX2 vld | EX3 vld. The clock must run until the final EX3 pass and the DRAIN->IDLE update are complete.
- Counter width is 3 bits; it never exceeds MAX_PASS, so no wrap.

Test Plan:
- Reset: cpurst_b low mid-ISSUE with N=4 -> all outputs 0 immediately; after release, no seq_done and no ex3_pass_vld.
- Single pass: req at T with pass_num=1 -> pipedown/pass_last at T; ex3_pass_vld idx0 and seq_done at T+2; seq_busy high T+1..T+2 only.
- Four passes: req at T with pass_num=4 -> pass_idx 0,1,2,3 at T..T+3, pass_last at T+3; ex3_pass_idx 0..3 at T+2..T+5; seq_done at T+5; new req accepted at T+6.
- Clamp: pass_num=0 -> behaves as N=1. pass_num=7 -> behaves as N=4.
- Flush mid-sequence: N=4, flush at T+2 -> no pipedown at T+2; ex3_pass_vld absent from T+3; no seq_done; busy=0 at T+3. Flush coincident with req in IDLE -> no pipedown, busy stays 0.
- Illegal req while busy, plus clock enable: req at T+1 during an N=3 sequence -> ignored, pass_idx sequence unchanged. seq_clk_en stays 1 from T through T+N+1, drops at T+N+2.
